mem_wb_skid_reg: RTL and testbench
==================================

// Module: mem_wb_skid_reg
// PURPOSE
//  Parametrised MEM->WB pipeline register with valid/ready handshake and a 2-entry skid buffer.
//  Holds wb_en, mem_read, dest, ALU result and load data between the MEM and WB stages.
//  Supports back-pressure from WB and a flush that inserts a bubble.
//  in_ready is a pure register output, so it breaks the combinational ready path between stages.
// PARAMETERS
//  DATA_W  32  width of the ALU result and of the memory data
//  DEST_W  4   width of the destination register index
//  CNT_W   16  width of the stall-cycle counter (saturating)
// PORTS
//  clk           in   1       clock; all state updates on its rising edge
//  rst           in   1       synchronous reset, active-high
//  flush         in   1       drop all held entries (bubble)
//  in_valid      in   1       MEM stage presents a transfer
//  in_ready      out  1       register can accept; = !skid_valid
//  wb_en         in   1       write-back enable of incoming op
//  mem_read      in   1       incoming op is a load
//  dest          in   DEST_W  destination register
//  alu           in   DATA_W  ALU result
//  data_memory   in   DATA_W  load data
//  out_valid     out  1       WB entry valid
//  out_ready     in   1       WB consumes the entry
//  wb_en_out     out  1       stored wb_en AND out_valid
//  mem_read_out  out  1       stored mem_read
//  dest_out      out  DEST_W  stored dest
//  alu_out       out  DATA_W  stored ALU result
//  data_memory_out out DATA_W stored load data
//  stall_cnt     out  CNT_W   count of cycles with out_valid & !out_ready
//  fwd_valid     out  1       forwarding entry valid (see CONFIGURATION)
//  fwd_dest      out  DEST_W  forwarding destination
//  fwd_data      out  DATA_W  forwarding value
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): occupancy 0, out_valid=0, in_ready=1 on the next cycle, all payload
//    outputs 0, stall_cnt=0. Reset mid-transfer discards all entries. No payload is X.
//  - Accept on in_valid&in_ready; deliver on out_valid&out_ready. Latency in->out is 1 cycle when empty.
//  - Storage: main entry (drives the outputs) and skid entry. Occupancy states:
//    EMPTY: accept -> ONE.
//    ONE: accept&deliver -> ONE (main <= input); accept only -> TWO (skid <= input);
//      deliver only -> EMPTY.
//    TWO (in_ready=0): deliver -> ONE (main <= skid).
//  - Ordering is strict FIFO; no transfer is ever lost or duplicated.
//  - Throughput is 1 per cycle while out_ready=1.
//  - flush=1: next state EMPTY regardless of in_valid/out_ready; any same-cycle accept is dropped.
//    Flush has priority over everything except rst.
//  - Dropped entries' payload registers may hold stale data. wb_en_out is forced to 0 whenever out_valid=0.
//  - stall_cnt increments each cycle with out_valid=1 and out_ready=0.
//    It saturates at 2^CNT_W-1 and is cleared only by rst.
//  - Payload widths are exact; no sign/zero extension inside the block.
// CONFIGURATION
//  MEM_WB_FWD_EN defined:
//    fwd_valid = out_valid & wb_en_out.
//    fwd_dest = dest_out.
//    fwd_data = mem_read_out ? data_memory_out : alu_out.
//    All three are combinational from the main entry, for the EX-stage forwarding unit.
//  MEM_WB_FWD_EN undefined: ports remain; fwd_valid, fwd_dest, fwd_data tied to 0; no mux logic.
// TESTING
//  1. Reset, then a single transfer: rst 2 cycles, in_valid=1 for 1 cycle with dest=4'h3,
//     alu=32'h0000_00AA, out_ready=1 -> out_valid=1 the next cycle with dest_out=3 and
//     alu_out=32'hAA, in_ready=1 throughout.
//  2. Back-pressure: out_ready=0 while 3 ops (A,B,C) are offered back-to-back ->
//     A held at the outputs, B held in skid, in_ready=0 after B, C not accepted.
//     Then out_ready=1 -> A, B, C delivered in order; stall_cnt equals the stalled cycles.
//  3. Flush: with occupancy TWO, flush=1 and in_valid=1 in the same cycle ->
//     next cycle out_valid=0, wb_en_out=0, in_ready=1; the offered op never appears.
//  4. Reset mid-operation: occupancy TWO, rst=1 for 1 cycle ->
//     out_valid=0, all payload outputs 0, stall_cnt=0.
//  5. Forwarding (MEM_WB_FWD_EN): main entry mem_read=1, wb_en=1, alu=32'h10,
//     data_memory=32'hDEAD_BEEF -> fwd_valid=1, fwd_data=32'hDEAD_BEEF.
//     Same stimulus without the macro -> all fwd_* = 0.
//  6. Saturation: CNT_W=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt stops at 4'hF.

Source files
------------

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register with a valid/ready handshake, a 2-entry skid buffer and a saturating stall counter.
// Optional EX-stage forwarding outputs are enabled by defining MEM_WB_FWD_EN; otherwise they are tied to 0.
module mem_wb_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en,
  input  logic              mem_read,
  input  logic [DEST_W-1:0] dest,
  input  logic [DATA_W-1:0] alu,
  input  logic [DATA_W-1:0] data_memory,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en_out,
  output logic              mem_read_out,
  output logic [DEST_W-1:0] dest_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] data_memory_out,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              fwd_valid,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_data
);

  // Payload layout: {wb_en, mem_read, dest, alu, data_memory}
  localparam int PAY_W = 2 + DEST_W + 2 * DATA_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [PAY_W-1:0]   main_q, main_d;
  logic [PAY_W-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [PAY_W-1:0]   in_pay_s;
  logic               accept_s;
  logic               deliver_s;

  assign in_pay_s  = {wb_en, mem_read, dest, alu, data_memory};
  assign accept_s  = in_valid & in_ready_q;
  assign deliver_s = out_valid_q & out_ready;

  // Occupancy transitions, entry loads and saturating stall counter.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;
    if (out_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d = ST_ONE;
            main_d  = in_pay_s;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && deliver_s) begin
            main_d = in_pay_s;
          end else if (accept_s) begin
            state_d = ST_TWO;
            skid_d  = in_pay_s;
          end else if (deliver_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (deliver_s) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and payload registers; in_ready/out_valid are registered copies of the next occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= {PAY_W{1'b0}};
      skid_q      <= {PAY_W{1'b0}};
      stall_q     <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_q     <= stall_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign wb_en_out       = main_q[PAY_W-1] & out_valid_q;
  assign mem_read_out    = main_q[PAY_W-2];
  assign dest_out        = main_q[2*DATA_W +: DEST_W];
  assign alu_out         = main_q[DATA_W +: DATA_W];
  assign data_memory_out = main_q[0 +: DATA_W];
  assign stall_cnt       = stall_q;

`ifdef MEM_WB_FWD_EN
  assign fwd_valid = out_valid_q & wb_en_out;
  assign fwd_dest  = dest_out;
  assign fwd_data  = mem_read_out ? data_memory_out : alu_out;
`else
  assign fwd_valid = 1'b0;
  assign fwd_dest  = {DEST_W{1'b0}};
  assign fwd_data  = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed self-checking bench for mem_wb_skid_reg (CNT_W=4 so stall saturation is reachable quickly).
module tb_mem_wb_skid_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wb_en = 1'b0;
  logic        mem_read = 1'b0;
  logic [3:0]  dest = 4'h0;
  logic [31:0] alu = 32'h0;
  logic [31:0] data_memory = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        wb_en_out;
  logic        mem_read_out;
  logic [3:0]  dest_out;
  logic [31:0] alu_out;
  logic [31:0] data_memory_out;
  logic [3:0]  stall_cnt;
  logic        fwd_valid;
  logic [3:0]  fwd_dest;
  logic [31:0] fwd_data;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  mem_wb_skid_reg #(.DATA_W(32), .DEST_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .wb_en(wb_en), .mem_read(mem_read), .dest(dest), .alu(alu), .data_memory(data_memory),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_en_out(wb_en_out), .mem_read_out(mem_read_out), .dest_out(dest_out),
    .alu_out(alu_out), .data_memory_out(data_memory_out), .stall_cnt(stall_cnt),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic we, input logic mr, input logic [3:0] d,
                       input logic [31:0] a, input logic [31:0] dm);
    in_valid    = v;
    wb_en       = we;
    mem_read    = mr;
    dest        = d;
    alu         = a;
    data_memory = dm;
  endtask

  initial begin
    // 1. reset and single transfer
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_dest", 32'(dest_out), 32'h0);
    check("rst_alu", alu_out, 32'h0);
    check("rst_stall", 32'(stall_cnt), 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    offer(1'b1, 1'b1, 1'b0, 4'h3, 32'h0000_00AA, 32'h0);
    tick();
    offer(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("t1_out_valid", 32'(out_valid), 32'h1);
    check("t1_dest", 32'(dest_out), 32'h3);
    check("t1_alu", alu_out, 32'h0000_00AA);
    check("t1_wb_en", 32'(wb_en_out), 32'h1);
    check("t1_in_ready", 32'(in_ready), 32'h1);
    tick();
    check("t1_drained", 32'(out_valid), 32'h0);
    check("t1_wb_en_idle", 32'(wb_en_out), 32'h0);

    // throughput: one per cycle with out_ready=1
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 1'b0, 1'b0, 4'(i + 8), 32'(i + 32'h100), 32'h0);
      tick();
      check("thr_dest", 32'(dest_out), 32'(i + 8));
      check("thr_alu", alu_out, 32'(i + 32'h100));
      check("thr_in_ready", 32'(in_ready), 32'h1);
    end
    offer(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    check("thr_drained", 32'(out_valid), 32'h0);

    // 2. back-pressure with A, B, C
    out_ready = 1'b0;
    offer(1'b1, 1'b1, 1'b0, 4'h1, 32'h11, 32'h0);
    tick();
    check("bp_a_valid", 32'(out_valid), 32'h1);
    check("bp_a_ready", 32'(in_ready), 32'h1);
    offer(1'b1, 1'b1, 1'b0, 4'h2, 32'h22, 32'h0);
    tick();
    check("bp_b_ready", 32'(in_ready), 32'h0);
    check("bp_b_dest", 32'(dest_out), 32'h1);
    offer(1'b1, 1'b1, 1'b0, 4'h3, 32'h33, 32'h0);
    tick();
    check("bp_c_ready", 32'(in_ready), 32'h0);
    check("bp_c_hold_a", alu_out, 32'h11);
    check("bp_stall2", 32'(stall_cnt), 32'h2);
    out_ready = 1'b1;
    tick();
    check("bp_out_b", 32'(dest_out), 32'h2);
    check("bp_out_b_alu", alu_out, 32'h22);
    check("bp_ready_again", 32'(in_ready), 32'h1);
    tick();
    offer(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("bp_out_c", 32'(dest_out), 32'h3);
    check("bp_out_c_alu", alu_out, 32'h33);
    tick();
    check("bp_drained", 32'(out_valid), 32'h0);
    check("bp_stall_final", 32'(stall_cnt), 32'h2);

    // 3. flush with occupancy TWO and a same-cycle offer
    out_ready = 1'b0;
    offer(1'b1, 1'b1, 1'b0, 4'h5, 32'h55, 32'h0);
    tick();
    offer(1'b1, 1'b1, 1'b0, 4'h6, 32'h66, 32'h0);
    tick();
    check("fl_two", 32'(in_ready), 32'h0);
    flush = 1'b1;
    offer(1'b1, 1'b1, 1'b0, 4'h7, 32'h77, 32'h0);
    tick();
    flush = 1'b0;
    offer(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("fl_out_valid", 32'(out_valid), 32'h0);
    check("fl_wb_en", 32'(wb_en_out), 32'h0);
    check("fl_in_ready", 32'(in_ready), 32'h1);
    out_ready = 1'b1;
    tick();
    check("fl_no_ghost", 32'(out_valid), 32'h0);
    check("fl_stall_kept", 32'(stall_cnt), 32'h4);

    // 4. reset mid-operation with occupancy TWO
    out_ready = 1'b0;
    offer(1'b1, 1'b1, 1'b1, 4'hA, 32'hAAAA_0001, 32'hCAFE_0001);
    tick();
    offer(1'b1, 1'b1, 1'b1, 4'hB, 32'hBBBB_0002, 32'hCAFE_0002);
    tick();
    check("mr_two", 32'(in_ready), 32'h0);
    rst = 1'b1;
    offer(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    check("mr_out_valid", 32'(out_valid), 32'h0);
    check("mr_dest", 32'(dest_out), 32'h0);
    check("mr_alu", alu_out, 32'h0);
    check("mr_dm", data_memory_out, 32'h0);
    check("mr_mem_read", 32'(mem_read_out), 32'h0);
    check("mr_stall", 32'(stall_cnt), 32'h0);
    check("mr_in_ready", 32'(in_ready), 32'h1);
    out_ready = 1'b1;
    tick();
    check("mr_skid_gone", 32'(out_valid), 32'h0);

    // 5. forwarding from the main entry
    out_ready = 1'b0;
    offer(1'b1, 1'b1, 1'b1, 4'h9, 32'h10, 32'hDEAD_BEEF);
    tick();
    offer(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("fw_mem_read", 32'(mem_read_out), 32'h1);
    check("fw_dm", data_memory_out, 32'hDEAD_BEEF);
`ifdef MEM_WB_FWD_EN
    check("fw_valid", 32'(fwd_valid), 32'h1);
    check("fw_dest", 32'(fwd_dest), 32'h9);
    check("fw_data", fwd_data, 32'hDEAD_BEEF);
`else
    check("fw_valid", 32'(fwd_valid), 32'h0);
    check("fw_dest", 32'(fwd_dest), 32'h0);
    check("fw_data", fwd_data, 32'h0);
`endif

    // 6. stall counter saturation
    for (int i = 0; i < 14; i++) tick();
    check("sat_14", 32'(stall_cnt), 32'hE);
    for (int i = 0; i < 6; i++) tick();
    check("sat_max", 32'(stall_cnt), 32'hF);
    check("sat_hold_valid", 32'(out_valid), 32'h1);
    check("sat_hold_dest", 32'(dest_out), 32'h9);
    out_ready = 1'b1;
    tick();
    check("sat_drained", 32'(out_valid), 32'h0);
    check("sat_kept", 32'(stall_cnt), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
